// File: rtl/trace_capture_if.sv
// -----------------------------------------------------------------------------
// trace_capture_if
//
// Bus between the trace recorder and its user (a bench or a debug port).
// Sampling/control flows into the recorder; readback and status flow out.
//
// Signals:
//   sample_in   packed processor samples, channel k at [k*WIDTH +: WIDTH]
//   on_change   1: store a sample only when it differs from the last stored one
//   arm         single-cycle pulse; clears the buffer and starts a capture
//   trig_value  trigger compare value for channel 0
//   rd_en       pop the oldest entry (honoured only once the capture is done)
//   rd_data     popped entry
//   rd_valid    rd_data valid for one cycle
//   count       number of valid entries in the buffer
//   cap_state   0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   overflow    sticky; an unread entry was overwritten since the last arm
//
// Modports:
//   master  user side (drives sampling/control, observes readback/status)
//   slave   recorder side
// -----------------------------------------------------------------------------
interface trace_capture_if #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16
);
  localparam int DW = CHANNELS * WIDTH;
  localparam int CW = $clog2(DEPTH + 1);

  logic [DW-1:0]    sample_in;
  logic             on_change;
  logic             arm;
  logic [WIDTH-1:0] trig_value;
  logic             rd_en;
  logic [DW-1:0]    rd_data;
  logic             rd_valid;
  logic [CW-1:0]    count;
  logic [1:0]       cap_state;
  logic             overflow;

  modport master (
    output sample_in, on_change, arm, trig_value, rd_en,
    input  rd_data, rd_valid, count, cap_state, overflow
  );

  modport slave (
    input  sample_in, on_change, arm, trig_value, rd_en,
    output rd_data, rd_valid, count, cap_state, overflow
  );
endinterface

// File: rtl/trace_capture.sv
// -----------------------------------------------------------------------------
// trace_capture
//
// On-chip trace recorder for the multicycle processor. Records a packed bundle
// of processor signals (PC on channel 0, then FSM state, ALU, store data, ...)
// into a circular buffer. Once armed it records continuously (or only on
// change), keeps the newest DEPTH entries, and stops POST writes after the
// entry whose channel 0 matches trig_value. The capture is then popped one
// entry per rd_en, oldest first.
//
// Parameters:
//   WIDTH     bits per channel
//   CHANNELS  number of channels; channel 0 is the trigger channel
//   DEPTH     buffer entries, power of two, >= 2
//   POST      entries written after the trigger entry, 0 .. DEPTH-1
//
// Ports:
//   clk    rising-edge clock
//   Reset  asynchronous, active-high reset
//   bus    trace_capture_if.slave (sampling, control, readback, status)
// -----------------------------------------------------------------------------
module trace_capture #(
  parameter int WIDTH    = 64,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 16,
  parameter int POST     = 8
) (
  input  logic             clk,
  input  logic             Reset,
  trace_capture_if.slave   bus
);

  localparam int DW = CHANNELS * WIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  // POST never exceeds DEPTH-1, so a pointer-wide counter holds it.
  localparam int PW = (AW < 1) ? 1 : AW;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [1:0]    r_state;
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [PW-1:0] r_post_cnt;
  logic          r_overflow;
  logic          r_last_valid;   // a sample has been stored since arm
  logic [DW-1:0] r_last;         // copy of the newest stored sample
  logic [DW-1:0] r_rd_data;
  logic          r_rd_valid;

  logic [DW-1:0] r_mem [DEPTH];

  // ---------------------------------------------------------------------------
  // Write / read decisions
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] w_ch0;
  logic             w_capturing;
  logic             w_trig;
  logic             w_wr_cond;
  logic             w_wr;
  logic             w_rd;
  logic             w_full;

  // NOTE: every signal assigned in always_comb gets a default on the first
  // lines of the block, so no path can leave it unassigned and infer a latch.
  always_comb begin
    w_ch0       = '0;
    w_capturing = 1'b0;
    w_trig      = 1'b0;
    w_wr_cond   = 1'b0;
    w_wr        = 1'b0;
    w_rd        = 1'b0;
    w_full      = 1'b0;

    w_ch0       = bus.sample_in[WIDTH-1:0];
    w_capturing = (r_state == S_ARMED) || (r_state == S_POST);
    w_trig      = (r_state == S_ARMED) && (w_ch0 == bus.trig_value);

    // The first sample after arm always goes in; afterwards on_change
    // suppresses repeats of the newest stored sample (all channels compared).
    w_wr_cond   = !bus.on_change || !r_last_valid || (bus.sample_in != r_last);

    // arm outranks everything, including a trigger match on the same cycle.
    w_wr        = !bus.arm && w_capturing && (w_wr_cond || w_trig);
    w_rd        = !bus.arm && (r_state == S_DONE) && bus.rd_en && (r_count != '0);
    w_full      = (r_count == CW'(DEPTH));
  end

  // ---------------------------------------------------------------------------
  // Control, pointers, status and readback register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register in this block sees the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_post_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_last_valid <= 1'b0;
      r_last       <= '0;
      r_rd_data    <= '0;
      r_rd_valid   <= 1'b0;
    end else if (bus.arm) begin
      // Fresh capture: the arm-cycle sample itself is not recorded.
      r_state      <= S_ARMED;
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_post_cnt   <= '0;
      r_overflow   <= 1'b0;
      r_last_valid <= 1'b0;
      r_rd_valid   <= 1'b0;
    end else begin
      r_rd_valid <= w_rd;

      if (w_wr) begin
        r_wr_ptr     <= r_wr_ptr + AW'(1);
        r_last       <= bus.sample_in;
        r_last_valid <= 1'b1;
        if (!w_full) begin
          r_count <= r_count + CW'(1);
        end else begin
          // Buffer full: the oldest entry is dropped to make room.
          r_rd_ptr   <= r_rd_ptr + AW'(1);
          r_overflow <= 1'b1;
        end
      end

      // Trigger entry counts as the write that opens the post window; the
      // POST-th write after it closes the capture.
      case (r_state)
        S_ARMED: begin
          if (w_trig) begin
            if (POST == 0) begin
              r_state <= S_DONE;
            end else begin
              r_state    <= S_POST;
              r_post_cnt <= PW'(POST);
            end
          end
        end
        S_POST: begin
          if (w_wr) begin
            r_post_cnt <= r_post_cnt - PW'(1);
            if (r_post_cnt == PW'(1)) begin
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          r_state <= r_state;
        end
      endcase

      // Reads only happen in DONE, so they never collide with a write.
      if (w_rd) begin
        r_rd_data <= r_mem[r_rd_ptr];
        r_rd_ptr  <= r_rd_ptr + AW'(1);
        r_count   <= r_count - CW'(1);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sample storage
  // ---------------------------------------------------------------------------
  // NOTE: the storage array has no reset; count and the pointers define which
  // entries are meaningful, and leaving it unreset lets it map onto RAM.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= bus.sample_in;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.rd_data   = r_rd_data;
  assign bus.rd_valid  = r_rd_valid;
  assign bus.count     = r_count;
  assign bus.cap_state = r_state;
  assign bus.overflow  = r_overflow;

endmodule

// File: tb/tb_trace_capture.sv
// -----------------------------------------------------------------------------
// tb_trace_capture
//
// Directed bench for trace_capture. Two small instances (DEPTH=4, CHANNELS=2,
// WIDTH=8): dut_a with POST=2 and dut_b with POST=0. Inputs change 1 ns after
// the rising edge and outputs are observed at that point too, well clear of
// the active edge. Channel 1 holds a fixed tag per instance so full-width
// readback is checked, not just channel 0.
// -----------------------------------------------------------------------------
module tb_trace_capture;

  localparam int WIDTH    = 8;
  localparam int CHANNELS = 2;
  localparam int DEPTH    = 4;

  localparam logic [7:0] TAG_A = 8'hA5;
  localparam logic [7:0] TAG_B = 8'h3C;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_POST  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic clk;
  logic rst;

  int n_vec  = 0;
  int n_fail = 0;

  trace_capture_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus_a ();
  trace_capture_if #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) bus_b ();

  trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .POST(2)) dut_a (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus_a)
  );

  trace_capture #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH), .POST(0)) dut_b (
    .clk   (clk),
    .Reset (rst),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic [7:0] ch0, input logic a, input logic r);
    bus_a.sample_in = {TAG_A, ch0};
    bus_a.arm       = a;
    bus_a.rd_en     = r;
  endtask

  task automatic set_b(input logic [7:0] ch0, input logic a, input logic r);
    bus_b.sample_in = {TAG_B, ch0};
    bus_b.arm       = a;
    bus_b.rd_en     = r;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.on_change = 1'b0; bus_a.trig_value = 8'h00; set_a(8'h00, 1'b0, 1'b0);
    bus_b.on_change = 1'b0; bus_b.trig_value = 8'h00; set_b(8'h00, 1'b0, 1'b0);
    #12;
    check("rst_state", 32'(bus_a.cap_state), 32'(S_IDLE));
    check("rst_count", 32'(bus_a.count), 0);
    check("rst_rdata", 32'(bus_a.rd_data), 0);
    rst = 1'b0;
    tick();

    // rd_en in IDLE is ignored.
    set_a(8'h00, 1'b0, 1'b1);
    tick();
    check("idle_rd_valid", 32'(bus_a.rd_valid), 0);

    // ---- asynchronous reset in the middle of a capture ----
    bus_a.trig_value = 8'd3;
    set_a(8'd1, 1'b1, 1'b0); tick();
    set_a(8'd2, 1'b0, 1'b0); tick();
    set_a(8'd3, 1'b0, 1'b0); tick();
    check("pre_rst_state", 32'(bus_a.cap_state), 32'(S_POST));
    check("pre_rst_count", 32'(bus_a.count), 2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_state", 32'(bus_a.cap_state), 32'(S_IDLE));
    check("async_rst_count", 32'(bus_a.count), 0);
    check("async_rst_rd_valid", 32'(bus_a.rd_valid), 0);
    check("async_rst_overflow", 32'(bus_a.overflow), 0);
    #1 rst = 1'b0;
    tick();

    // ---- trigger window: arm with ch0=1, then 2..6, trig=3 ----
    bus_a.trig_value = 8'd3;
    set_a(8'd1, 1'b1, 1'b0); tick();
    check("tw_armed", 32'(bus_a.cap_state), 32'(S_ARMED));
    check("tw_arm_count", 32'(bus_a.count), 0);
    set_a(8'd2, 1'b0, 1'b0); tick();
    check("tw_count_1", 32'(bus_a.count), 1);
    set_a(8'd3, 1'b0, 1'b0); tick();
    check("tw_trig_state", 32'(bus_a.cap_state), 32'(S_POST));
    set_a(8'd4, 1'b0, 1'b0); tick();
    check("tw_post_state", 32'(bus_a.cap_state), 32'(S_POST));
    set_a(8'd5, 1'b0, 1'b0); tick();
    check("tw_done_state", 32'(bus_a.cap_state), 32'(S_DONE));
    check("tw_done_count", 32'(bus_a.count), 4);
    check("tw_overflow", 32'(bus_a.overflow), 0);
    set_a(8'd6, 1'b0, 1'b1); tick();
    check("tw_rd0_valid", 32'(bus_a.rd_valid), 1);
    check("tw_rd0_data", 32'(bus_a.rd_data), 32'({TAG_A, 8'd2}));
    check("tw_rd0_count", 32'(bus_a.count), 3);
    tick();
    check("tw_rd1_data", 32'(bus_a.rd_data), 32'({TAG_A, 8'd3}));
    tick();
    check("tw_rd2_data", 32'(bus_a.rd_data), 32'({TAG_A, 8'd4}));
    tick();
    check("tw_rd3_data", 32'(bus_a.rd_data), 32'({TAG_A, 8'd5}));
    check("tw_rd3_valid", 32'(bus_a.rd_valid), 1);
    tick();
    check("tw_rd4_valid", 32'(bus_a.rd_valid), 0);
    check("tw_rd4_hold", 32'(bus_a.rd_data), 32'({TAG_A, 8'd5}));
    check("tw_rd4_count", 32'(bus_a.count), 0);
    set_a(8'd6, 1'b0, 1'b0); tick();
    check("tw_no_valid_idle", 32'(bus_a.rd_valid), 0);

    // ---- wrap-around: arm with 10, then 11..17, trig=15 ----
    bus_a.trig_value = 8'd15;
    set_a(8'd10, 1'b1, 1'b0); tick();
    check("wr_arm_overflow_clr", 32'(bus_a.overflow), 0);
    for (int v = 11; v <= 14; v++) begin
      set_a(8'(v), 1'b0, 1'b0); tick();
    end
    check("wr_full_count", 32'(bus_a.count), 4);
    check("wr_no_ovf_yet", 32'(bus_a.overflow), 0);
    for (int v = 15; v <= 17; v++) begin
      set_a(8'(v), 1'b0, 1'b0); tick();
    end
    check("wr_done_state", 32'(bus_a.cap_state), 32'(S_DONE));
    check("wr_done_count", 32'(bus_a.count), 4);
    check("wr_overflow", 32'(bus_a.overflow), 1);
    for (int k = 0; k < 4; k++) begin
      set_a(8'd0, 1'b0, 1'b1); tick();
      check($sformatf("wr_rd%0d_data", k), 32'(bus_a.rd_data), 32'({TAG_A, 8'(14 + k)}));
    end
    set_a(8'd0, 1'b0, 1'b0); tick();

    // ---- arm/trigger collision: trig=5 ----
    bus_a.trig_value = 8'd5;
    set_a(8'd1, 1'b1, 1'b0); tick();
    set_a(8'd2, 1'b0, 1'b0); tick();
    check("col_pre_count", 32'(bus_a.count), 1);
    set_a(8'd5, 1'b1, 1'b0); tick();
    check("col_state", 32'(bus_a.cap_state), 32'(S_ARMED));
    check("col_count", 32'(bus_a.count), 0);
    set_a(8'd5, 1'b0, 1'b0); tick();
    check("col_trig_state", 32'(bus_a.cap_state), 32'(S_POST));
    check("col_trig_count", 32'(bus_a.count), 1);
    set_a(8'd6, 1'b0, 1'b0); tick();
    set_a(8'd7, 1'b0, 1'b0); tick();
    check("col_done_state", 32'(bus_a.cap_state), 32'(S_DONE));
    set_a(8'd0, 1'b0, 1'b1); tick();
    check("col_rd0_data", 32'(bus_a.rd_data), 32'({TAG_A, 8'd5}));
    set_a(8'd0, 1'b0, 1'b0); tick();

    // ---- on_change filtering on the POST=0 instance: 1,1,1,2,2,3, trig=9 ----
    bus_b.on_change  = 1'b1;
    bus_b.trig_value = 8'd9;
    set_b(8'd1, 1'b1, 1'b0); tick();
    set_b(8'd1, 1'b0, 1'b0); tick();
    set_b(8'd1, 1'b0, 1'b0); tick();
    check("oc_repeat_count", 32'(bus_b.count), 1);
    set_b(8'd2, 1'b0, 1'b0); tick();
    set_b(8'd2, 1'b0, 1'b0); tick();
    set_b(8'd3, 1'b0, 1'b0); tick();
    check("oc_count", 32'(bus_b.count), 3);
    check("oc_state", 32'(bus_b.cap_state), 32'(S_ARMED));
    set_b(8'd9, 1'b0, 1'b0); tick();
    check("oc_trig_state", 32'(bus_b.cap_state), 32'(S_DONE));
    check("oc_trig_count", 32'(bus_b.count), 4);
    for (int k = 0; k < 3; k++) begin
      set_b(8'd9, 1'b0, 1'b1); tick();
      check($sformatf("oc_rd%0d_data", k), 32'(bus_b.rd_data), 32'({TAG_B, 8'(k + 1)}));
    end
    tick();
    check("oc_rd3_data", 32'(bus_b.rd_data), 32'({TAG_B, 8'd9}));
    set_b(8'd9, 1'b0, 1'b0); tick();

    // ---- POST=0: writes 4,5,6,8 then trigger 7, then re-arm in DONE ----
    bus_b.on_change  = 1'b0;
    bus_b.trig_value = 8'd7;
    set_b(8'd0, 1'b1, 1'b0); tick();
    set_b(8'd4, 1'b0, 1'b0); tick();
    set_b(8'd5, 1'b0, 1'b0); tick();
    set_b(8'd6, 1'b0, 1'b0); tick();
    set_b(8'd8, 1'b0, 1'b0); tick();
    check("p0_pre_state", 32'(bus_b.cap_state), 32'(S_ARMED));
    set_b(8'd7, 1'b0, 1'b0); tick();
    check("p0_done_state", 32'(bus_b.cap_state), 32'(S_DONE));
    check("p0_done_count", 32'(bus_b.count), 4);
    check("p0_overflow", 32'(bus_b.overflow), 1);
    set_b(8'd7, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick();
    end
    check("p0_newest_data", 32'(bus_b.rd_data), 32'({TAG_B, 8'd7}));
    check("p0_drained_count", 32'(bus_b.count), 0);
    check("p0_ovf_sticky", 32'(bus_b.overflow), 1);
    set_b(8'd7, 1'b1, 1'b0); tick();
    check("p0_rearm_state", 32'(bus_b.cap_state), 32'(S_ARMED));
    check("p0_rearm_count", 32'(bus_b.count), 0);
    check("p0_rearm_overflow", 32'(bus_b.overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/trace_capture.md
# trace_capture

Parametrised on-chip trace recorder for the multicycle processor. It replaces `$monitor`-style observation of PC, FSM state, ALU and store values with a synthesizable, multi-channel circular buffer. The buffer has a trigger and a post-trigger window, so a capture can be inspected from a bench or a debug port. It sits beside `unidadeProcessamento`, takes a packed bundle of processor signals, and is read back one entry per request.

## Interface
Parameters:
- WIDTH, 64, bits per channel
- CHANNELS, 4, number of channels; channel 0 is the trigger channel (normally PC)
- DEPTH, 16, buffer entries; power of two, ≥ 2
- POST, 8, entries written after the trigger entry; 0 ≤ POST ≤ DEPTH−1

Ports:
- clk  in  1  clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- sample_in  in  CHANNELS*WIDTH  packed samples; channel k at [k*WIDTH +: WIDTH]
- on_change  in  1  0: write every cycle while capturing; 1: write only when sample_in differs from the last written entry
- arm  in  1  single-cycle pulse; clears the buffer and starts a capture
- trig_value  in  WIDTH  trigger compare value for channel 0
- rd_en  in  1  pop the oldest entry (honoured only in DONE)
- rd_data  out  CHANNELS*WIDTH  popped entry
- rd_valid  out  1  rd_data valid for one cycle
- count  out  $clog2(DEPTH+1)  number of valid entries
- cap_state  out  2  0 IDLE, 1 ARMED, 2 POST, 3 DONE
- overflow  out  1  sticky; set when an unread entry has been overwritten since the last arm

## Operation
- **Reset**: all outputs are 0, the state is IDLE, and the pointers are 0.
- **Arm**: `arm` in any state sets wr_ptr = rd_ptr = count = 0 and clears overflow and the last-sample valid flag. The next state is ARMED. The sample on the arm cycle is not written. `arm` has priority over every other event.
- **Write condition** in ARMED or POST: `on_change`=0, or no sample has been written since arm, or sample_in ≠ the last written sample (compared across all channels).
- **Trigger**: in ARMED, if channel 0 == trig_value, the sample is written regardless of the write condition.
  - POST>0: the next state is POST with post_cnt = POST.
  - POST=0: the next state is DONE.
- **POST**: each write decrements post_cnt. The write that takes post_cnt to 0 moves the state to DONE.
- **Buffer writes**: each write goes to mem[wr_ptr] and wr_ptr increments modulo DEPTH.
  - If count < DEPTH, count increments.
  - Otherwise rd_ptr increments (the oldest entry is dropped) and overflow is set.
- **DONE**:
  - No writes.
  - `rd_en` with count>0 registers mem[rd_ptr] into rd_data, increments rd_ptr, and decrements count.
  - `rd_en` with count==0 is ignored, and rd_valid stays 0.
- **IDLE**: no writes; `rd_en` is ignored.
- **rd_data**: holds its last value when rd_valid is 0.

## Timing
- sample_in, arm, rd_en and trig_value are sampled on the rising edge of clk.
- A write is visible in count and cap_state on the cycle after the edge.
- Trigger to DONE takes POST+1 write cycles: the trigger write plus POST writes. With `on_change`=1, that time stretches by the number of unchanged cycles.
- Read latency is 1: rd_en at edge N gives rd_data/rd_valid after edge N. Back-to-back rd_en gives one entry per cycle, oldest first.
- **Reset mid-operation**: asynchronous, so the buffer contents become don't-care, the state is IDLE and all outputs are 0 at once.
- **arm in the same cycle as a trigger match**: the arm wins and nothing is written.

## Test plan
- **Reset**: with DEPTH=4, CHANNELS=2, WIDTH=8, POST=2, assert Reset mid-capture → cap_state=0, count=0, rd_valid=0, overflow=0 immediately, without waiting for a clock edge.
- **Trigger window**: arm, then ch0 = 1,2,3,4,5,6 with trig_value=3 → DONE after the sample-5 write, count=4, overflow=0. rd_en ×5 → ch0 = 2,3,4,5, then no rd_valid on the 5th.
- **Wrap-around**: arm, then ch0 = 10..17 with trig_value=15 → entries read back as 14,15,16,17, overflow=1.
- **on_change filtering**: `on_change`=1, ch0 = 1,1,1,2,2,3 with trig_value=9 → count=3, readback 1,2,3, state stays ARMED.
- **POST=0 and re-arm**: trigger at ch0=7 → DONE on the next cycle, count includes 7 as the newest entry. arm in DONE → count=0, overflow=0, ARMED.
- **Arm/trigger collision**: arm asserted while ch0 == trig_value in ARMED → no write, count=0, ARMED; the next matching sample triggers normally.
